instr_fetch_unit: RTL

- Sits between the receive FIFO (fifo_rx) and the controller's decode stage.
- Pops bytes from the receive FIFO and assembles them little-endian into 16-bit instruction words.
- For address-carrying STORE instructions, also fetches the trailing 2-byte address.
- Drops NOP and illegal opcodes, latches HALT, recovers from truncated frames by timeout, and presents each instruction over a valid/ready handshake.

---
 rtl/utpu_pkg.sv | 20 ++
 rtl/instr_fetch_unit.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/utpu_pkg.sv
// Shared definitions for the micro-TPU front end: opcode encoding and instruction field positions.
package utpu_pkg;

  typedef enum logic [2:0] {
    OP_STORE = 3'd0,
    OP_FETCH = 3'd1,
    OP_RUN   = 3'd2,
    OP_LOAD  = 3'd3,
    OP_HALT  = 3'd4,
    OP_NOP   = 3'd5
  } opcode_e;

  // STORE instructions with this bit set carry a trailing 2-byte address.
  localparam int STORE_ADDR_BIT = 4;

  function automatic logic is_illegal_op(input logic [2:0] op);
    return (op == 3'd6) || (op == 3'd7);
  endfunction

endpackage

// File: rtl/instr_fetch_unit.sv
// Pops bytes from the receive FIFO, assembles little-endian instruction words (plus an optional
// store address) and hands them to decode over valid/ready; filters NOP/illegal and recovers from truncated frames.
module instr_fetch_unit
  import utpu_pkg::*;
#(
  parameter int FIFO_DATA_WIDTH  = 8,
  parameter int BUFFER_WORD_SIZE = 16,
  parameter int ADDRESS_SIZE     = 9,
  parameter int OPCODE_WIDTH     = 3,
  parameter int TIMEOUT_CYCLES   = 1024,
  parameter int TIMEOUT_WIDTH    = $clog2(TIMEOUT_CYCLES)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        fifo_empty,
  input  logic [FIFO_DATA_WIDTH-1:0]  fifo_r_data,
  output logic                        fifo_re,
  output logic                        instr_valid,
  input  logic                        instr_ready,
  output logic [BUFFER_WORD_SIZE-1:0] instr_word,
  output logic [OPCODE_WIDTH-1:0]     instr_opcode,
  output logic [ADDRESS_SIZE-1:0]     store_addr,
  output logic                        has_addr,
  output logic                        halted,
  output logic                        frame_error,
  output logic                        illegal_op
);

  typedef enum logic [2:0] {
    FETCH_LO  = 3'd0,
    FETCH_HI  = 3'd1,
    FETCH_ALO = 3'd2,
    FETCH_AHI = 3'd3,
    PRESENT   = 3'd4,
    HALTED    = 3'd5
  } fetch_state_e;

  localparam logic [TIMEOUT_WIDTH-1:0] TIMEOUT_LAST = TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1);

  fetch_state_e                state_r, state_s;
  logic                        rd_pending_r;
  logic [TIMEOUT_WIDTH-1:0]    tmo_cnt_r, tmo_cnt_s;
  logic [FIFO_DATA_WIDTH-1:0]  lo_byte_r, lo_byte_s;
  logic [FIFO_DATA_WIDTH-1:0]  alo_byte_r, alo_byte_s;
  logic [BUFFER_WORD_SIZE-1:0] word_r, word_s;
  logic [ADDRESS_SIZE-1:0]     addr_r, addr_s;
  logic                        has_addr_r, has_addr_s;
  logic                        valid_r, valid_s;
  logic                        halted_r, halted_s;
  logic                        frame_error_r, frame_error_s;
  logic                        illegal_r, illegal_s;
  logic                        in_fetch_s, idle_tick_s, fifo_re_s;
  logic [OPCODE_WIDTH-1:0]     lo_op_s;

  // A pop is only legal with no read in flight, so the byte rate is at most one per two cycles.
  assign in_fetch_s  = (state_r == FETCH_LO) || (state_r == FETCH_HI) ||
                       (state_r == FETCH_ALO) || (state_r == FETCH_AHI);
  assign fifo_re_s   = rst && in_fetch_s && !fifo_empty && !rd_pending_r;
  assign idle_tick_s = ((state_r == FETCH_HI) || (state_r == FETCH_ALO) || (state_r == FETCH_AHI)) &&
                       !rd_pending_r && fifo_empty;
  assign lo_op_s     = lo_byte_r[OPCODE_WIDTH-1:0];

  assign fifo_re      = fifo_re_s;
  assign instr_valid  = valid_r;
  assign instr_word   = word_r;
  assign instr_opcode = word_r[OPCODE_WIDTH-1:0];
  assign store_addr   = addr_r;
  assign has_addr     = has_addr_r;
  assign halted       = halted_r;
  assign frame_error  = frame_error_r;
  assign illegal_op   = illegal_r;

  // Next-state and next-output logic for the fetch sequencer.
  always_comb begin
    state_s       = state_r;
    tmo_cnt_s     = '0;
    lo_byte_s     = lo_byte_r;
    alo_byte_s    = alo_byte_r;
    word_s        = word_r;
    addr_s        = addr_r;
    has_addr_s    = has_addr_r;
    valid_s       = valid_r;
    halted_s      = halted_r;
    frame_error_s = 1'b0;
    illegal_s     = 1'b0;

    case (state_r)
      FETCH_LO: begin
        if (rd_pending_r) begin
          lo_byte_s = fifo_r_data;
          state_s   = FETCH_HI;
        end else begin
          state_s = FETCH_LO;
        end
      end
      FETCH_HI: begin
        if (!rd_pending_r) begin
          state_s = FETCH_HI;
        end else if (is_illegal_op(lo_op_s)) begin
          illegal_s = 1'b1;
          state_s   = FETCH_LO;
        end else if (lo_op_s == OP_NOP) begin
          state_s = FETCH_LO;
        end else if ((lo_op_s == OP_STORE) && lo_byte_r[STORE_ADDR_BIT]) begin
          word_s  = {fifo_r_data, lo_byte_r};
          state_s = FETCH_ALO;
        end else begin
          word_s     = {fifo_r_data, lo_byte_r};
          has_addr_s = 1'b0;
          addr_s     = '0;
          valid_s    = 1'b1;
          state_s    = PRESENT;
        end
      end
      FETCH_ALO: begin
        if (rd_pending_r) begin
          alo_byte_s = fifo_r_data;
          state_s    = FETCH_AHI;
        end else begin
          state_s = FETCH_ALO;
        end
      end
      FETCH_AHI: begin
        if (rd_pending_r) begin
          addr_s     = ADDRESS_SIZE'({fifo_r_data, alo_byte_r});
          has_addr_s = 1'b1;
          valid_s    = 1'b1;
          state_s    = PRESENT;
        end else begin
          state_s = FETCH_AHI;
        end
      end
      PRESENT: begin
        if (valid_r && instr_ready) begin
          valid_s = 1'b0;
          if (word_r[OPCODE_WIDTH-1:0] == OP_HALT) begin
            halted_s = 1'b1;
            state_s  = HALTED;
          end else begin
            state_s = FETCH_LO;
          end
        end else begin
          state_s = PRESENT;
        end
      end
      HALTED: begin
        halted_s = 1'b1;
        state_s  = HALTED;
      end
      default: begin
        state_s = FETCH_LO;
      end
    endcase

    // Counter only survives on consecutive starved cycles mid-frame; anything else clears it.
    if (idle_tick_s) begin
      if (tmo_cnt_r == TIMEOUT_LAST) begin
        frame_error_s = 1'b1;
        state_s       = FETCH_LO;
      end else begin
        tmo_cnt_s = tmo_cnt_r + TIMEOUT_WIDTH'(1);
      end
    end else begin
      tmo_cnt_s = '0;
    end
  end

  // State and holding registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r       <= FETCH_LO;
      rd_pending_r  <= 1'b0;
      tmo_cnt_r     <= '0;
      lo_byte_r     <= '0;
      alo_byte_r    <= '0;
      word_r        <= '0;
      addr_r        <= '0;
      has_addr_r    <= 1'b0;
      valid_r       <= 1'b0;
      halted_r      <= 1'b0;
      frame_error_r <= 1'b0;
      illegal_r     <= 1'b0;
    end else begin
      state_r       <= state_s;
      rd_pending_r  <= fifo_re_s;
      tmo_cnt_r     <= tmo_cnt_s;
      lo_byte_r     <= lo_byte_s;
      alo_byte_r    <= alo_byte_s;
      word_r        <= word_s;
      addr_r        <= addr_s;
      has_addr_r    <= has_addr_s;
      valid_r       <= valid_s;
      halted_r      <= halted_s;
      frame_error_r <= frame_error_s;
      illegal_r     <= illegal_s;
    end
  end

endmodule
